// File: rtl/inst_fetch_ctrl.sv
// Fetch controller: owns the PC, addresses the 1-cycle-latency instruction ROM and
// steers the instruction manager between ROM data, the held instruction and a NOP.
`ifndef INST_MEM
`define INST_MEM 2'd0
`endif
`ifndef INST_OLD
`define INST_OLD 2'd1
`endif
`ifndef INST_NOP
`define INST_NOP 2'd2
`endif

module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_ADDR_W  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    output logic [IMEM_ADDR_W-1:0] iaddr,
    output logic [1:0]             inst_sel,
    output logic                   inst_valid,
    output logic [31:0]            pc,
    output logic [31:0]            pc_id
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_id;
    logic [31:0] w_tgt;

    assign w_tgt = branch_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VECTOR;
            r_pc_id <= RESET_VECTOR;
        end else if (branch_taken) begin
            // Data arriving next cycle is wrong-path; FLUSH turns it into a NOP.
            r_state <= S_FLUSH;
            r_pc    <= w_tgt;
        end else if (stall) begin
            // BOOT and FLUSH have no real instruction to hold, so they keep emitting NOPs.
            if (r_state == S_RUN || r_state == S_STALL)
                r_state <= S_STALL;
        end else begin
            r_state <= S_RUN;
            r_pc    <= r_pc + 32'd4;
            r_pc_id <= r_pc;
        end
    end

    always_comb begin
        inst_sel   = `INST_NOP;
        inst_valid = 1'b0;
        case (r_state)
            S_RUN:   begin inst_sel = `INST_MEM; inst_valid = 1'b1; end
            S_STALL: begin inst_sel = `INST_OLD; inst_valid = 1'b1; end
            default: begin inst_sel = `INST_NOP; inst_valid = 1'b0; end
        endcase
    end

    assign pc    = r_pc;
    assign pc_id = r_pc_id;
    assign iaddr = r_pc[IMEM_ADDR_W+1:2];

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table for the boot/stall/branch/wrap
// corners, then random traffic against a behavioural fetch model.
`ifndef INST_MEM
`define INST_MEM 2'd0
`endif
`ifndef INST_OLD
`define INST_OLD 2'd1
`endif
`ifndef INST_NOP
`define INST_NOP 2'd2
`endif

module tb_inst_fetch_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [31:0]   branch_target = 32'h0;
    logic [AW-1:0] iaddr;
    logic [1:0]    inst_sel;
    logic          inst_valid;
    logic [31:0]   pc;
    logic [31:0]   pc_id;

    int n_vec = 0;
    int n_bad = 0;

    inst_fetch_ctrl #(.RESET_VECTOR(32'h0), .IMEM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .iaddr(iaddr), .inst_sel(inst_sel),
        .inst_valid(inst_valid), .pc(pc), .pc_id(pc_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [1:0]  e_sel;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc_id;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] t,
                                input logic [1:0] es, input logic ev, input logic [31:0] ep,
                                input logic [31:0] epid);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t;
        v.e_sel = es; v.e_valid = ev; v.e_pc = ep; v.e_pc_id = epid;
        return v;
    endfunction

    task automatic check(input string tag, input int idx, input logic [1:0] es, input logic ev,
                         input logic [31:0] ep, input logic [31:0] epid);
        logic [31:0] w_ep;
        logic [AW-1:0] ea;
        w_ep = ep;
        ea = w_ep[AW+1:2];
        n_vec++;
        if (inst_sel !== es || inst_valid !== ev || pc !== ep || pc_id !== epid || iaddr !== ea) begin
            n_bad++;
            $display("FAIL %s #%0d: got sel=%0d valid=%0b pc=%h pc_id=%h iaddr=%h, want sel=%0d valid=%0b pc=%h pc_id=%h iaddr=%h",
                     tag, idx, inst_sel, inst_valid, pc, pc_id, iaddr, es, ev, ep, epid, ea);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks whether the manager output is a real instruction and
    // whether it is being held, rather than any controller state.
    logic [31:0] m_pc, m_pc_id;
    bit          m_real, m_held;

    function automatic void model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
        if (r) begin
            m_pc = 32'h0; m_pc_id = 32'h0; m_real = 0; m_held = 0;
        end else if (b) begin
            m_pc = {t[31:2], 2'b00}; m_real = 0; m_held = 0;
        end else if (s) begin
            m_held = m_real;
        end else begin
            m_pc_id = m_pc; m_pc = m_pc + 32'd4; m_real = 1; m_held = 0;
        end
    endfunction

    initial begin
        logic [1:0] es;
        // Boot: two reset cycles, then fetch 0,4,8,C
        tbl.push_back(mk(1,0,0,0,            `INST_NOP,0,32'h0,32'h0));
        tbl.push_back(mk(1,0,0,0,            `INST_NOP,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h4,32'h0));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h8,32'h4));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'hC,32'h8));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h10,32'hC));
        // Stall x3 at pc=0x10, then release
        tbl.push_back(mk(0,1,0,0,            `INST_OLD,1,32'h10,32'hC));
        tbl.push_back(mk(0,1,0,0,            `INST_OLD,1,32'h10,32'hC));
        tbl.push_back(mk(0,1,0,0,            `INST_OLD,1,32'h10,32'hC));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h14,32'h10));
        // Branch to 0x40
        tbl.push_back(mk(0,0,1,32'h40,       `INST_NOP,0,32'h40,32'h10));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h44,32'h40));
        // Branch+stall with misaligned target, stall held in FLUSH
        tbl.push_back(mk(0,1,1,32'h43,       `INST_NOP,0,32'h40,32'h40));
        tbl.push_back(mk(0,1,0,0,            `INST_NOP,0,32'h40,32'h40));
        tbl.push_back(mk(0,1,0,0,            `INST_NOP,0,32'h40,32'h40));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h44,32'h40));
        // Wrap at top of address space
        tbl.push_back(mk(0,0,1,32'hFFFF_FFFC,`INST_NOP,0,32'hFFFF_FFFC,32'h40));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h0,32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h4,32'h0));
        // Reset mid-stall, restart as boot
        tbl.push_back(mk(0,1,0,0,            `INST_OLD,1,32'h4,32'h0));
        tbl.push_back(mk(1,1,0,0,            `INST_NOP,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h4,32'h0));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h8,32'h4));
        // Stall during BOOT keeps NOP
        tbl.push_back(mk(1,0,0,0,            `INST_NOP,0,32'h0,32'h0));
        tbl.push_back(mk(0,1,0,0,            `INST_NOP,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,0,0,            `INST_MEM,1,32'h4,32'h0));

        #2;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].tgt);
            check("table", i, tbl[i].e_sel, tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_pc_id);
        end

        // Random phase, model started from a reset
        drive(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            b = ($urandom_range(0, 99) < 10);
            s = ($urandom_range(0, 99) < 30);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            drive(r, s, b, t);
            model_step(r, s, b, t);
            es = !m_real ? `INST_NOP : (m_held ? `INST_OLD : `INST_MEM);
            check("random", i, es, m_real, m_pc, m_pc_id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
